video_scanout: RTL

Frame-buffer and raster scan-out stage directly downstream of the CPU-side video write cache. It stores the 8-bit pixel bytes the cache delivers on its 15-bit video address bus into a 30000-byte frame buffer (200×150 pixels, one byte per pixel). It also generates raster timing and streams pixels plus sync signals to the display output, one pixel per clock.

---
 rtl/video_scanout.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/video_scanout.sv
// video_scanout: frame buffer plus raster scan-out for a 200x150, 8-bit display.
// The write cache stores pixel bytes into a 30000-byte simple dual-port memory.
// A free-running raster generator reads the memory back, one pixel per clock,
// and drives pixel colour and sync signals through a 3-stage pipeline
// (counters/address, memory read, output registers).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   vAddress   in   15-bit frame-buffer byte address (writes)
//   vData      in   pixel byte to store
//   wEnable    in   write strobe, one byte per cycle
//   pixel      out  registered pixel colour, 0 outside the visible area
//   hSync      out  horizontal sync, active-low
//   vSync      out  vertical sync, active-low
//   active     out  high while pixel carries visible data
//   frameStart out  one-cycle pulse with pixel (0,0)
module video_scanout #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [14:0]       vAddress,
  input  logic [DATA_W-1:0] vData,
  input  logic              wEnable,
  output logic [DATA_W-1:0] pixel,
  output logic              hSync,
  output logic              vSync,
  output logic              active,
  output logic              frameStart
);

  localparam logic [7:0]  H_ACTIVE     = 8'd200;
  localparam logic [7:0]  H_SYNC_START = 8'd208;  // H_ACTIVE + H_FRONT
  localparam logic [7:0]  H_SYNC_END   = 8'd232;  // + H_SYNC
  localparam logic [7:0]  H_LAST       = 8'd255;  // H_TOTAL - 1
  localparam logic [7:0]  V_ACTIVE     = 8'd150;
  localparam logic [7:0]  V_ROW_LAST   = 8'd149;  // last line that advances rowBase
  localparam logic [7:0]  V_SYNC_START = 8'd153;  // V_ACTIVE + V_FRONT
  localparam logic [7:0]  V_SYNC_END   = 8'd157;  // + V_SYNC
  localparam logic [7:0]  V_LAST       = 8'd159;  // V_TOTAL - 1
  localparam logic [14:0] MEM_DEPTH    = 15'd30000;
  localparam logic [14:0] ROW_STEP     = 15'd200;

  logic [DATA_W-1:0] mem [0:29999];

  logic [7:0]  hcnt_p0_q, hcnt_p0_d;
  logic [7:0]  vcnt_p0_q, vcnt_p0_d;
  logic [14:0] rowbase_p0_q, rowbase_p0_d;
  logic        vis_p0, hs_p0, vs_p0, first_p0;
  logic [14:0] rd_addr_p0;

  logic [DATA_W-1:0] rdata_p1_q;
  logic              vis_p1_q, hs_p1_q, vs_p1_q, first_p1_q;

  logic [DATA_W-1:0] pixel_p2_q;
  logic              active_p2_q, hsync_p2_q, vsync_p2_q, fstart_p2_q;

  // ---- Stage 0: raster counters and read address ----
  // rowBase tracks 200*vCount by repeated addition; it stops advancing after
  // the last visible line so it never points past the buffer.
  always_comb begin
    hcnt_p0_d    = hcnt_p0_q + 8'd1;
    vcnt_p0_d    = vcnt_p0_q;
    rowbase_p0_d = rowbase_p0_q;
    if (hcnt_p0_q == H_LAST) begin
      hcnt_p0_d = 8'd0;
      if (vcnt_p0_q == V_LAST) begin
        vcnt_p0_d    = 8'd0;
        rowbase_p0_d = 15'd0;
      end else begin
        vcnt_p0_d = vcnt_p0_q + 8'd1;
        if (vcnt_p0_q < V_ROW_LAST) rowbase_p0_d = rowbase_p0_q + ROW_STEP;
      end
    end
  end

  assign vis_p0     = (hcnt_p0_q < H_ACTIVE) && (vcnt_p0_q < V_ACTIVE);
  assign hs_p0      = (hcnt_p0_q >= H_SYNC_START) && (hcnt_p0_q < H_SYNC_END);
  assign vs_p0      = (vcnt_p0_q >= V_SYNC_START) && (vcnt_p0_q < V_SYNC_END);
  assign first_p0   = (hcnt_p0_q == 8'd0) && (vcnt_p0_q == 8'd0);
  assign rd_addr_p0 = rowbase_p0_q + {7'd0, hcnt_p0_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_p0_q    <= 8'd0;
      vcnt_p0_q    <= 8'd0;
      rowbase_p0_q <= 15'd0;
    end else begin
      hcnt_p0_q    <= hcnt_p0_d;
      vcnt_p0_q    <= vcnt_p0_d;
      rowbase_p0_q <= rowbase_p0_d;
    end
  end

  // Write port: out-of-range addresses are dropped, never wrapped.
  always_ff @(posedge clk) begin
    if (wEnable && (vAddress < MEM_DEPTH)) mem[vAddress] <= vData;
  end

  // ---- Stage 1: memory read and delayed raster flags ----
  // Read and write are separate processes on the same edge, so a same-address
  // collision returns the byte stored before this edge.
  always_ff @(posedge clk) begin
    if (vis_p0) rdata_p1_q <= mem[rd_addr_p0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vis_p1_q   <= 1'b0;
      hs_p1_q    <= 1'b0;
      vs_p1_q    <= 1'b0;
      first_p1_q <= 1'b0;
    end else begin
      vis_p1_q   <= vis_p0;
      hs_p1_q    <= hs_p0;
      vs_p1_q    <= vs_p0;
      first_p1_q <= first_p0;
    end
  end

  // ---- Stage 2: output registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_p2_q  <= '0;
      active_p2_q <= 1'b0;
      hsync_p2_q  <= 1'b1;
      vsync_p2_q  <= 1'b1;
      fstart_p2_q <= 1'b0;
    end else begin
      pixel_p2_q  <= vis_p1_q ? rdata_p1_q : '0;
      active_p2_q <= vis_p1_q;
      hsync_p2_q  <= ~hs_p1_q;
      vsync_p2_q  <= ~vs_p1_q;
      fstart_p2_q <= first_p1_q;
    end
  end

  assign pixel      = pixel_p2_q;
  assign active     = active_p2_q;
  assign hSync      = hsync_p2_q;
  assign vSync      = vsync_p2_q;
  assign frameStart = fstart_p2_q;

endmodule
